// File: rtl/clksel_ctrl.sv
// Clock-switch initiator: requests the fast CPU clock when allowed, picks the divider,
// and waits for the switch's synchronised acknowledgements before changing state.
module clksel_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int TIMEOUT        = 255,
  parameter int CNT_W          = 8
) (
  input  logic       lsclk_in,
  input  logic       rst,
  input  logic       hs_enable_cfg,
  input  logic [1:0] div_cfg,
  input  logic       slow_req,
  input  logic       hsclk_selected,
  input  logic       lsclk_selected,
  output logic       hsclk_sel,
  output logic [1:0] cpuclk_div_sel,
  output logic       in_hs,
  output logic       switch_busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    ST_LS    = 2'b00,
    ST_TO_HS = 2'b01,
    ST_HS    = 2'b10,
    ST_TO_LS = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] TO_MAX    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]       to_cnt_q, to_cnt_d;
  logic [SYNC_STAGES-1:0] hs_sync_q, hs_sync_d;
  logic [SYNC_STAGES-1:0] ls_sync_q, ls_sync_d;
  logic                   hsclk_sel_q, hsclk_sel_d;
  logic [1:0]             div_sel_q, div_sel_d;
  logic                   in_hs_q, in_hs_d;
  logic                   busy_q, busy_d;
  logic                   terr_q, terr_d;
  logic                   hs_ack_s, ls_ack_s;
  logic                   abort_s;
  logic [CNT_W-1:0]       to_inc_s;

  assign hs_ack_s = hs_sync_q[SYNC_STAGES-1];
  assign ls_ack_s = ls_sync_q[SYNC_STAGES-1];

  assign hsclk_sel      = hsclk_sel_q;
  assign cpuclk_div_sel = div_sel_q;
  assign in_hs          = in_hs_q;
  assign switch_busy    = busy_q;
  assign timeout_err    = terr_q;

  always_ff @(posedge lsclk_in or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LS;
      hold_cnt_q  <= HOLD_INIT;
      to_cnt_q    <= CNT_ZERO;
      hs_sync_q   <= {SYNC_STAGES{1'b0}};
      ls_sync_q   <= {SYNC_STAGES{1'b1}};
      hsclk_sel_q <= 1'b0;
      div_sel_q   <= 2'b00;
      in_hs_q     <= 1'b0;
      busy_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      to_cnt_q    <= to_cnt_d;
      hs_sync_q   <= hs_sync_d;
      ls_sync_q   <= ls_sync_d;
      hsclk_sel_q <= hsclk_sel_d;
      div_sel_q   <= div_sel_d;
      in_hs_q     <= in_hs_d;
      busy_q      <= busy_d;
      terr_q      <= terr_d;
    end
  end

  always_comb begin
    hs_sync_d   = {hs_sync_q[SYNC_STAGES-2:0], hsclk_selected};
    ls_sync_d   = {ls_sync_q[SYNC_STAGES-2:0], lsclk_selected};
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    to_cnt_d    = to_cnt_q;
    hsclk_sel_d = hsclk_sel_q;
    div_sel_d   = div_sel_q;
    terr_d      = terr_q;
    abort_s     = slow_req | ~hs_enable_cfg;
    to_inc_s    = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + CNT_ONE;

    case (state_q)
      ST_LS: begin
        if (slow_req) begin
          hold_cnt_d = HOLD_INIT;
        end else if (hold_cnt_q != CNT_ZERO) begin
          hold_cnt_d = hold_cnt_q - CNT_ONE;
        end else begin
          hold_cnt_d = CNT_ZERO;
        end
        if ((hold_cnt_q == CNT_ZERO) && hs_enable_cfg && !slow_req && ls_ack_s) begin
          state_d     = ST_TO_HS;
          hsclk_sel_d = 1'b1;
          div_sel_d   = div_cfg[1] ? 2'b10 : div_cfg;
          to_cnt_d    = CNT_ZERO;
        end
      end
      // Abort outranks a same-cycle ack, which outranks the timeout.
      ST_TO_HS: begin
        if (abort_s) begin
          state_d     = ST_TO_LS;
          hsclk_sel_d = 1'b0;
          to_cnt_d    = CNT_ZERO;
        end else if (hs_ack_s) begin
          state_d = ST_HS;
        end else if (to_cnt_q == TO_MAX) begin
          state_d     = ST_TO_LS;
          hsclk_sel_d = 1'b0;
          terr_d      = 1'b1;
          to_cnt_d    = CNT_ZERO;
        end else begin
          to_cnt_d = to_inc_s;
        end
      end
      ST_HS: begin
        if (abort_s) begin
          state_d     = ST_TO_LS;
          hsclk_sel_d = 1'b0;
          to_cnt_d    = CNT_ZERO;
        end
      end
      ST_TO_LS: begin
        if (ls_ack_s && !hs_ack_s) begin
          state_d    = ST_LS;
          hold_cnt_d = HOLD_INIT;
        end else if (to_cnt_q == TO_MAX) begin
          terr_d = 1'b1;
        end else begin
          to_cnt_d = to_inc_s;
        end
      end
      default: begin
        state_d     = ST_LS;
        hsclk_sel_d = 1'b0;
        hold_cnt_d  = HOLD_INIT;
        to_cnt_d    = CNT_ZERO;
      end
    endcase
  end

  // Status flags are registered from the next state so they move with the state itself.
  always_comb begin
    in_hs_d = (state_d == ST_HS);
    busy_d  = (state_d == ST_TO_HS) || (state_d == ST_TO_LS);
  end

endmodule

// File: tb/tb_clksel_ctrl.sv
// Self-checking bench for clksel_ctrl: vector table plus hand-written timeout/reset sequences,
// with expected outputs queued at drive time and popped after each clock edge.
module tb_clksel_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       hs_en;
  logic [1:0] div;
  logic       slow;
  logic       hsa;
  logic       lsa;
  logic       hsclk_sel;
  logic [1:0] div_sel;
  logic       in_hs;
  logic       busy;
  logic       terr;
  logic [5:0] outs;

  typedef struct {
    logic       slow;
    logic       en;
    logic [1:0] div;
    logic       hsa;
    logic       lsa;
    logic [5:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] exp;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  clksel_ctrl dut (
    .lsclk_in      (clk),
    .rst           (rst),
    .hs_enable_cfg (hs_en),
    .div_cfg       (div),
    .slow_req      (slow),
    .hsclk_selected(hsa),
    .lsclk_selected(lsa),
    .hsclk_sel     (hsclk_sel),
    .cpuclk_div_sel(div_sel),
    .in_hs         (in_hs),
    .switch_busy   (busy),
    .timeout_err   (terr)
  );

  always #5 clk = ~clk;

  assign outs = {hsclk_sel, div_sel, in_hs, busy, terr};

  // Pack expected outputs as {hsclk_sel, div_sel, in_hs, switch_busy, timeout_err}.
  function automatic logic [5:0] o(input logic h, input logic [1:0] d, input logic ih,
                                   input logic b, input logic t);
    return {h, d, ih, b, t};
  endfunction

  task automatic add(input logic s, input logic e, input logic [1:0] d, input logic ha,
                     input logic la, input logic [5:0] x, input int n);
    vec_t v;
    v.slow = s; v.en = e; v.div = d; v.hsa = ha; v.lsa = la; v.exp = x;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic cmp_pop(input logic [5:0] act);
    sb_t e;
    e = sb_q.pop_front();
    n_cmp++;
    if (act !== e.exp) begin
      n_bad++;
      $display("FAIL %s got=%b want=%b", e.name, act, e.exp);
    end
  endtask

  task automatic push(input string name, input logic [5:0] x);
    sb_t e;
    e.name = name; e.exp = x;
    sb_q.push_back(e);
  endtask

  task automatic step(input vec_t v, input string name);
    slow = v.slow; hs_en = v.en; div = v.div; hsa = v.hsa; lsa = v.lsa;
    push(name, v.exp);
    @(posedge clk); #1;
    cmp_pop(outs);
  endtask

  task automatic chk(input string name, input logic [5:0] x);
    push(name, x);
    cmp_pop(outs);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // sel=0 waits for hsclk_sel=1, sel=1 waits for switch_busy=0; an expired budget is a failure.
  task automatic wait_for(input int sel, input int max, input string name);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) begin
      @(posedge clk); #1;
      hit = (sel == 0) ? hsclk_sel : !busy;
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL %s got=timeout want=event within %0d cycles", name, max);
    end
  endtask

  initial begin
    rst = 1'b1; slow = 1'b0; hs_en = 1'b1; div = 2'b01; hsa = 1'b0; lsa = 1'b1;
    tick(2);
    chk("reset_state", o(1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;

    // Holdoff after reset, then the request edge.
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v.slow = 1'b0; v.en = 1'b1; v.div = 2'b01; v.hsa = 1'b0; v.lsa = 1'b1;
      v.exp = o(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      step(v, $sformatf("holdoff_%0d", i));
    end
    wait_for(0, 3, "first_request");
    chk("first_request_outs", o(1'b1, 2'b01, 1'b0, 1'b1, 1'b0));

    // Ack to HS, div change ignored, slow pulse, holdoff, re-request, abort vs ack, enable abort.
    add(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, o(1'b1, 2'b01, 1'b0, 1'b1, 1'b0), 2);
    add(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, o(1'b1, 2'b01, 1'b1, 1'b0, 1'b0), 1);
    add(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, o(1'b1, 2'b01, 1'b1, 1'b0, 1'b0), 2);
    add(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, o(1'b0, 2'b01, 1'b0, 1'b1, 1'b0), 1);
    add(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, o(1'b0, 2'b01, 1'b0, 1'b1, 1'b0), 2);
    add(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, o(1'b0, 2'b01, 1'b0, 1'b0, 1'b0), 9);
    add(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, o(1'b1, 2'b10, 1'b0, 1'b1, 1'b0), 1);
    add(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, o(1'b1, 2'b10, 1'b0, 1'b1, 1'b0), 2);
    add(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, o(1'b0, 2'b10, 1'b0, 1'b1, 1'b0), 1);
    add(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, o(1'b0, 2'b10, 1'b0, 1'b1, 1'b0), 2);
    add(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, o(1'b0, 2'b10, 1'b0, 1'b0, 1'b0), 1);
    add(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, o(1'b0, 2'b10, 1'b0, 1'b0, 1'b0), 10);
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, o(1'b1, 2'b00, 1'b0, 1'b1, 1'b0), 1);
    add(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, o(1'b0, 2'b00, 1'b0, 1'b1, 1'b0), 1);
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, o(1'b0, 2'b00, 1'b0, 1'b0, 1'b0), 1);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec_%0d", i));

    // Ack never arrives: timeout after 256 cycles in TO_HS, divider 11 maps to 10.
    slow = 1'b0; hs_en = 1'b1; div = 2'b11; hsa = 1'b0; lsa = 1'b1;
    wait_for(0, 12, "to_request");
    chk("to_request_outs", o(1'b1, 2'b10, 1'b0, 1'b1, 1'b0));
    tick(255);
    chk("to_last_wait", o(1'b1, 2'b10, 1'b0, 1'b1, 1'b0));
    tick(1);
    chk("to_fire", o(1'b0, 2'b10, 1'b0, 1'b1, 1'b1));
    tick(1);
    chk("to_back_ls", o(1'b0, 2'b10, 1'b0, 1'b0, 1'b1));

    // Sticky error survives a successful switch.
    wait_for(0, 12, "sticky_request");
    chk("sticky_request_outs", o(1'b1, 2'b10, 1'b0, 1'b1, 1'b1));
    hsa = 1'b1; lsa = 1'b0;
    tick(3);
    chk("sticky_in_hs", o(1'b1, 2'b10, 1'b1, 1'b0, 1'b1));
    slow = 1'b1;
    tick(1);
    chk("sticky_to_ls", o(1'b0, 2'b10, 1'b0, 1'b1, 1'b1));
    slow = 1'b0; hsa = 1'b0; lsa = 1'b1;
    wait_for(1, 6, "sticky_ls_ack");
    chk("sticky_ls", o(1'b0, 2'b10, 1'b0, 1'b0, 1'b1));

    // Asynchronous reset while a fast request is outstanding.
    wait_for(0, 12, "rst_request");
    chk("rst_request_outs", o(1'b1, 2'b10, 1'b0, 1'b1, 1'b1));
    #2 rst = 1'b1;
    #1 chk("rst_async", o(1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    chk("rst_after", o(1'b0, 2'b00, 1'b0, 1'b0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
